// File: rtl/tff_toggle_sequencer.sv
// Sequencer that walks a bank of T flip-flops from bit 0 upward and pulses
// a single toggle enable for every bit whose Q differs from a latched target.
module tff_toggle_sequencer #(
  parameter int N         = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] target,
  input  logic [N-1:0] q,
  output logic [N-1:0] en,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [4:0]   toggles
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [2:0]    RETRY_LIMIT = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    PULSE,
    CHECK,
    DONE,
    ERROR
  } state_t;

  state_t         state_reg, state_next;
  logic [N-1:0]   tgt_reg, tgt_next;
  logic [IW-1:0]  idx_reg, idx_next;
  logic [2:0]     retry_reg, retry_next;
  logic [4:0]     toggles_reg, toggles_next;
  logic [N-1:0]   en_reg, en_next;
  logic           busy_reg, busy_next;
  logic           done_reg, done_next;
  logic           error_reg, error_next;

  // Per-bit disagreement between the bank and the latched target.
  logic [N-1:0] diff;
  logic         cur_diff;
  logic         at_last;

  for (genvar gi = 0; gi < N; gi++) begin : g_diff
    assign diff[gi] = q[gi] ^ tgt_reg[gi];
  end

  assign cur_diff = diff[idx_reg];
  assign at_last  = (idx_reg == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      tgt_reg     <= '0;
      idx_reg     <= '0;
      retry_reg   <= '0;
      toggles_reg <= '0;
      en_reg      <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      error_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tgt_reg     <= tgt_next;
      idx_reg     <= idx_next;
      retry_reg   <= retry_next;
      toggles_reg <= toggles_next;
      en_reg      <= en_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      error_reg   <= error_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    tgt_next     = tgt_reg;
    idx_next     = idx_reg;
    retry_next   = retry_reg;
    toggles_next = toggles_reg;
    en_next      = '0;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    error_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          tgt_next     = target;
          idx_next     = '0;
          retry_next   = '0;
          toggles_next = '0;
          busy_next    = 1'b1;
          state_next   = SCAN;
        end
      end

      SCAN: begin
        if (cur_diff) begin
          en_next      = {{(N-1){1'b0}}, 1'b1} << idx_reg;
          retry_next   = retry_reg + 3'd1;
          toggles_next = (toggles_reg == 5'd31) ? toggles_reg : toggles_reg + 5'd1;
          state_next   = PULSE;
        end else if (at_last) begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = DONE;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end

      // The bank samples en on the edge that closes this cycle.
      PULSE: begin
        state_next = CHECK;
      end

      CHECK: begin
        if (!cur_diff) begin
          if (at_last) begin
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = DONE;
          end else begin
            idx_next   = idx_reg + 1'b1;
            retry_next = '0;
            state_next = SCAN;
          end
        end else if (retry_reg == RETRY_LIMIT) begin
          error_next = 1'b1;
          busy_next  = 1'b0;
          state_next = ERROR;
        end else begin
          state_next = SCAN;
        end
      end

      DONE:    state_next = IDLE;
      ERROR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign en      = en_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign error   = error_reg;
  assign toggles = toggles_reg;

endmodule
